// File: rtl/route_compute_buf.sv
// Router input FIFO with XY route computed at enqueue; feeds the four-way split.
// Optional RCB_CORE_CNT_EN adds a 16-bit count of flits popped to the local core.
module route_compute_buf #(
   parameter int WIDTH  = 11,
   parameter int DEPTH  = 4,
   parameter int NODE_X = 0,
   parameter int NODE_Y = 0
) (
   input  logic                     CLK,
   input  logic                     _RESET,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [1:0]               out_ctrl,
   output logic                     out_core,
   output logic [$clog2(DEPTH):0]   occupancy
`ifdef RCB_CORE_CNT_EN
   ,
   output logic [15:0]              core_flit_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = WIDTH + 3;
   localparam logic [1:0] NX = 2'(NODE_X);
   localparam logic [1:0] NY = 2'(NODE_Y);

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic [1:0]    dx;
   logic [1:0]    dy;
   logic [1:0]    in_ctrl;
   logic          in_core;
   logic          push;
   logic          pop;
   logic [EW-1:0] head;

   assign dx = in_data[WIDTH-1:WIDTH-2];
   assign dy = in_data[WIDTH-3:WIDTH-4];

   // Conditions are mutually exclusive so the decode stays one-hot.
   always_comb begin
      in_ctrl = 2'b00;
      in_core = 1'b0;
      unique case (1'b1)
         (dx > NX):              in_ctrl = 2'b01;
         (dx < NX):              in_ctrl = 2'b11;
         (dx == NX && dy > NY):  in_ctrl = 2'b00;
         (dx == NX && dy < NY):  in_ctrl = 2'b10;
         default:                in_core = 1'b1;
      endcase
   end

   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign head      = mem[rd_ptr];
   assign out_data  = out_valid ? head[WIDTH-1:0]     : '0;
   assign out_ctrl  = out_valid ? head[WIDTH+1:WIDTH] : 2'b00;
   assign out_core  = out_valid ? head[WIDTH+2]       : 1'b0;
   assign occupancy = count;

   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= {in_core, in_ctrl, in_data};
      end
   end

   always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

`ifdef RCB_CORE_CNT_EN
   always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
         core_flit_cnt <= '0;
      end else if (pop && out_core) begin
         core_flit_cnt <= core_flit_cnt + 16'd1;
      end
   end
`endif

endmodule
